// File: rtl/pipe_stage_reg_gen.sv
// Inter-stage pipeline register with stall (hold), bubble (NOP inject) and hazard-profiling counters.
// Latency: 1 cycle d_i -> q_o; every output is a flop, no input-to-output combinational path.
// Backpressure: stall_i holds contents and ignores d_i; bubble_i overrides stall_i; rst_i overrides both.
module pipe_stage_reg_gen #(
    parameter int                 DATA_W     = 212,
    parameter logic [DATA_W-1:0]  RESET_VAL  = '0,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
    parameter logic [DATA_W-1:0]  KEEP_MASK  = '0,
    parameter int                 CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic              d_valid_i,
    output logic [DATA_W-1:0] q_o,
    output logic              q_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  hold_cnt_o,
    output logic [CNT_W-1:0]  hold_max_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counters stick at all-ones instead of wrapping, so a long hazard never reads as zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] bubble_dat;
    logic [CNT_W-1:0]  hold_nxt;
    logic              stall_eff;

    // Bubble payload: kept bits (stat, Cnd, ...) follow d_i, the rest become the NOP encoding.
    always_comb begin
        bubble_dat = (d_i & KEEP_MASK) | (BUBBLE_VAL & ~KEEP_MASK);
        hold_nxt   = sat_inc(hold_cnt_o);
        stall_eff  = stall_i && !bubble_i;
    end

    // Payload and valid: reset > bubble > stall (hold) > load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o       <= RESET_VAL;
            q_valid_o <= 1'b0;
        end else if (bubble_i) begin
            q_o       <= bubble_dat;
            q_valid_o <= 1'b0;
        end else if (!stall_i) begin
            q_o       <= d_i;
            q_valid_o <= d_valid_i;
        end
    end

    // Profiling counters; a simultaneous stall+bubble is accounted as a bubble only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
            hold_cnt_o   <= '0;
            hold_max_o   <= '0;
        end else if (bubble_i) begin
            bubble_cnt_o <= sat_inc(bubble_cnt_o);
            hold_cnt_o   <= '0;
        end else if (stall_eff) begin
            stall_cnt_o <= sat_inc(stall_cnt_o);
            hold_cnt_o  <= hold_nxt;
            if (hold_nxt > hold_max_o) begin
                hold_max_o <= hold_nxt;
            end
        end else begin
            hold_cnt_o <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg_gen.sv
// Bench for pipe_stage_reg_gen: two instances (32-bit and 3-bit counters) share one stimulus stream.
// Latency: outputs compared #1 after each posedge against a cycle-level reference model.
// Backpressure: stall/bubble/reset patterns are directed first, then randomized.
module tb_pipe_stage_reg_gen;

    localparam int DW = 212;
    localparam logic [DW-1:0] RV = {4'hA, {26{8'h5A}}};
    localparam logic [DW-1:0] BV = 212'h10;
    localparam logic [DW-1:0] KM = 212'h7;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1, stall_i = 1'b0, bubble_i = 1'b0, d_valid_i = 1'b0;
    logic [DW-1:0] d_i = '0;

    logic [DW-1:0] qa, qb;
    logic          va, vb;
    logic [31:0]   sa, ba, ha, ma;
    logic [2:0]    sb, bb, hb, mb;

    // Reference model state: raw (unbounded) counts, saturated only when compared.
    logic [DW-1:0] m_q = '0;
    logic          m_v = 1'b0;
    longint        m_st = 0, m_bu = 0, m_ho = 0, m_hm = 0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_gen #(.DATA_W(DW), .RESET_VAL(RV), .BUBBLE_VAL(BV), .KEEP_MASK(KM), .CNT_W(32)) u_a (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .bubble_i(bubble_i),
        .d_i(d_i), .d_valid_i(d_valid_i), .q_o(qa), .q_valid_o(va),
        .stall_cnt_o(sa), .bubble_cnt_o(ba), .hold_cnt_o(ha), .hold_max_o(ma)
    );

    pipe_stage_reg_gen #(.DATA_W(DW), .RESET_VAL(RV), .BUBBLE_VAL(BV), .KEEP_MASK(KM), .CNT_W(3)) u_b (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .bubble_i(bubble_i),
        .d_i(d_i), .d_valid_i(d_valid_i), .q_o(qb), .q_valid_o(vb),
        .stall_cnt_o(sb), .bubble_cnt_o(bb), .hold_cnt_o(hb), .hold_max_o(mb)
    );

    function automatic longint sat(input longint x, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    function automatic logic [DW-1:0] rnd_d();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW+128:0] obs_a();
        return {qa, va, sa, ba, ha, ma};
    endfunction

    function automatic logic [DW+12:0] obs_b();
        return {qb, vb, sb, bb, hb, mb};
    endfunction

    function automatic logic [DW+128:0] exp_a();
        return {m_q, m_v, 32'(sat(m_st, 32)), 32'(sat(m_bu, 32)), 32'(sat(m_ho, 32)), 32'(sat(m_hm, 32))};
    endfunction

    function automatic logic [DW+12:0] exp_b();
        return {m_q, m_v, 3'(sat(m_st, 3)), 3'(sat(m_bu, 3)), 3'(sat(m_ho, 3)), 3'(sat(m_hm, 3))};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit past it.
    task automatic step(input logic r, input logic s, input logic b, input logic [DW-1:0] dd, input logic dv);
        rst_i = r; stall_i = s; bubble_i = b; d_i = dd; d_valid_i = dv;
        @(posedge clk);
        if (r) begin
            m_q = RV; m_v = 1'b0; m_st = 0; m_bu = 0; m_ho = 0; m_hm = 0;
        end else if (b) begin
            m_q = (dd & KM) | (BV & ~KM); m_v = 1'b0; m_bu++; m_ho = 0;
        end else if (s) begin
            m_st++; m_ho++;
            if (m_ho > m_hm) m_hm = m_ho;
        end else begin
            m_q = dd; m_v = dv; m_ho = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 'x, 1'b1);
        step(1'b1, 1'b0, 1'b0, 'x, 1'b0);
        n_cmp++;
        if ({qa, va, sa, ba, ha, ma} !== {RV, 1'b0, 128'd0}) begin
            n_fail++;
            $display("FAIL reset_a: got q=%h v=%b s=%0d b=%0d h=%0d m=%0d", qa, va, sa, ba, ha, ma);
        end
        n_cmp++;
        if ({qb, vb, sb, bb, hb, mb} !== {RV, 1'b0, 12'd0}) begin
            n_fail++;
            $display("FAIL reset_b: got q=%h v=%b s=%0d b=%0d h=%0d m=%0d", qb, vb, sb, bb, hb, mb);
        end
    endtask

    task automatic test_load_stall();
        step(1'b0, 1'b0, 1'b0, 212'h1234, 1'b1);
        n_cmp++;
        if (qa !== 212'h1234 || va !== 1'b1) begin
            n_fail++;
            $display("FAIL load: got q=%h v=%b want q=1234 v=1", qa, va);
        end
        step(1'b0, 1'b1, 1'b0, rnd_d(), 1'b0);
        step(1'b0, 1'b1, 1'b0, 'x, 1'b1);
        step(1'b0, 1'b1, 1'b0, rnd_d(), 1'b0);
        n_cmp++;
        if (qa !== 212'h1234 || va !== 1'b1 || sa !== 32'd3 || ha !== 32'd3 || ma !== 32'd3) begin
            n_fail++;
            $display("FAIL stall3: got q=%h v=%b s=%0d h=%0d m=%0d want 1234 1 3 3 3", qa, va, sa, ha, ma);
        end
        step(1'b0, 1'b0, 1'b0, rnd_d(), 1'b0);
        n_cmp++;
        if (qa !== m_q || va !== 1'b0 || ha !== 32'd0 || ma !== 32'd3) begin
            n_fail++;
            $display("FAIL load_dv0: got q=%h v=%b h=%0d m=%0d want q=%h 0 0 3", qa, va, ha, ma, m_q);
        end
    endtask

    task automatic test_bubble();
        step(1'b0, 1'b0, 1'b1, 212'hFF5, 1'b1);
        n_cmp++;
        if (qa !== 212'h15 || va !== 1'b0 || ba !== 32'd1 || ha !== 32'd0 || sa !== 32'd3) begin
            n_fail++;
            $display("FAIL bubble: got q=%h v=%b b=%0d h=%0d s=%0d want 15 0 1 0 3", qa, va, ba, ha, sa);
        end
    endtask

    task automatic test_stall_bubble();
        step(1'b0, 1'b1, 1'b0, 'x, 1'b0);
        step(1'b0, 1'b1, 1'b1, 212'hFF5, 1'b1);
        n_cmp++;
        if (qa !== 212'h15 || va !== 1'b0 || ba !== 32'd2 || sa !== 32'd4 || ha !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_bubble: got q=%h v=%b b=%0d s=%0d h=%0d want 15 0 2 4 0", qa, va, ba, sa, ha);
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, rnd_d(), 1'b1);
        n_cmp++;
        if (sb !== 3'd7 || hb !== 3'd7 || mb !== 3'd7) begin
            n_fail++;
            $display("FAIL sat_b: got s=%0d h=%0d m=%0d want 7 7 7", sb, hb, mb);
        end
        n_cmp++;
        if (sa !== 32'd10 || ha !== 32'd10 || ma !== 32'd10) begin
            n_fail++;
            $display("FAIL nosat_a: got s=%0d h=%0d m=%0d want 10 10 10", sa, ha, ma);
        end
        step(1'b0, 1'b0, 1'b0, rnd_d(), 1'b1);
        n_cmp++;
        if (hb !== 3'd0 || mb !== 3'd7 || sb !== 3'd7) begin
            n_fail++;
            $display("FAIL sat_load_b: got h=%0d m=%0d s=%0d want 0 7 7", hb, mb, sb);
        end
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, rnd_d(), 1'b1);
        n_cmp++;
        if (bb !== 3'd7 || ba !== 32'd9) begin
            n_fail++;
            $display("FAIL sat_bubble: got b_b=%0d b_a=%0d want 7 9", bb, ba);
        end
    endtask

    task automatic test_reset_mid_stall();
        step(1'b0, 1'b0, 1'b0, 212'hABCD, 1'b1);
        step(1'b0, 1'b1, 1'b0, rnd_d(), 1'b0);
        step(1'b1, 1'b1, 1'b0, 'x, 1'b1);
        n_cmp++;
        if ({qa, va, sa, ba, ha, ma} !== {RV, 1'b0, 128'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_stall: got q=%h v=%b s=%0d b=%0d h=%0d m=%0d", qa, va, sa, ba, ha, ma);
        end
        step(1'b0, 1'b1, 1'b0, rnd_d(), 1'b1);
        n_cmp++;
        if (qa !== RV || ha !== 32'd1 || hb !== 3'd1 || sa !== 32'd1 || ma !== 32'd1) begin
            n_fail++;
            $display("FAIL post_rst_stall: got q=%h h_a=%0d h_b=%0d s=%0d m=%0d want h=1 s=1 m=1", qa, ha, hb, sa, ma);
        end
    endtask

    task automatic test_random();
        int pr, pb, ps;
        for (int i = 0; i < 3000; i++) begin
            // Alternate calm and stall-heavy phases so long holds and saturation both occur.
            ps = ((i / 200) % 2 == 1) ? 80 : 30;
            pr = $urandom_range(99, 0);
            pb = $urandom_range(99, 0);
            step(pr < 2, $urandom_range(99, 0) < ps, pb < 15, rnd_d(), 1'($urandom()));
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_fail++;
                $display("FAIL rand_a cyc %0d: got %h want %h", i, obs_a(), exp_a());
            end
            n_cmp++;
            if (obs_b() !== exp_b()) begin
                n_fail++;
                $display("FAIL rand_b cyc %0d: got %h want %h", i, obs_b(), exp_b());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_stall();
        test_bubble();
        test_stall_bubble();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
